step_ctrl: RTL and testbench

//  Input-conditioning stage directly upstream of the 0-9 up/down display counter.
//  - Synchronises and debounces the raw push-button btn and the direction switch sw.
//  - Produces a one-cycle step pulse per press, with optional auto-repeat while held.
//  - Produces a clean direction level dir; the counter advances one digit per step, in direction dir.

---
 rtl/step_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_step_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// step_ctrl: conditions a bouncy push-button and direction switch into one-cycle
// step pulses (with optional auto-repeat) and a clean direction level.
module step_ctrl #(
  parameter int DB_CYC  = 500000,
  parameter int REP_DLY = 25000000,
  parameter int REP_PER = 10000000
) (
  input  logic ck,
  input  logic rs,
  input  logic btn,
  input  logic sw,
  output logic step,
  output logic dir,
  output logic busy
);

  localparam int MAX_AB  = (DB_CYC > REP_DLY) ? DB_CYC : REP_DLY;
  localparam int MAX_CYC = (MAX_AB > REP_PER) ? MAX_AB : REP_PER;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] DLY_LAST = (REP_DLY == 0) ? '0 : CW'(REP_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PER - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_HOLD,
    S_REPEAT,
    S_RELEASE
  } state_t;

  logic          r_btn_meta;
  logic          r_btn_s;
  logic          r_sw_meta;
  logic          r_sw_s;

  logic [CW-1:0] r_dcnt;
  logic          r_dir;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_step;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_step_nxt;

  // The switch idles at "up", so its synchroniser resets to 1 to match dir.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_sw_meta  <= 1'b1;
      r_sw_s     <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes the pre-edge value of the one before;
      // blocking here would collapse the two-stage synchroniser into a single flop.
      r_btn_meta <= btn;
      r_btn_s    <= r_btn_meta;
      r_sw_meta  <= sw;
      r_sw_s     <= r_sw_meta;
    end
  end

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      r_dcnt <= '0;
      r_dir  <= 1'b1;
    end else if (r_sw_s == r_dir) begin
      r_dcnt <= '0;
    end else if (r_dcnt == DB_LAST) begin
      r_dir  <= r_sw_s;
      r_dcnt <= '0;
    end else begin
      r_dcnt <= r_dcnt + ONE;
    end
  end

  // A low btn_s is always tested before any counter terminal condition.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = S_PRESS;
          w_cnt_nxt   = '0;
        end
      end

      S_PRESS: begin
        if (!r_btn_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_step_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
        end
      end

      S_HOLD: begin
        if (!r_btn_s) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end else if (REP_DLY != 0) begin
          if (r_cnt == DLY_LAST) begin
            w_state_nxt = S_REPEAT;
            w_cnt_nxt   = '0;
            w_step_nxt  = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + ONE;
          end
        end
      end

      S_REPEAT: begin
        if (!r_btn_s) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PER_LAST) begin
          w_cnt_nxt   = '0;
          w_step_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
        end
      end

      S_RELEASE: begin
        // A bounce back high returns to HOLD silently and restarts the repeat delay.
        if (r_btn_s) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign step = r_step;
  assign dir  = r_dir;
  assign busy = r_busy;

  a_busy_tracks_state : assert property (
    @(posedge ck) disable iff (!rs) r_busy == (r_state != S_IDLE)
  );

  // Back-to-back steps are only possible with a one-cycle repeat delay or period.
  a_step_single : assert property (
    @(posedge ck) disable iff (!rs)
      (r_step && (REP_PER != 1) && (REP_DLY != 1)) |=> !r_step
  );

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DB_CYC=4, REP_DLY=10, REP_PER=3: vector table
// for press/glitch/bounce/direction cases plus hand-written auto-repeat and reset runs.
module tb_step_ctrl;

  localparam int DB_CYC  = 4;
  localparam int REP_DLY = 10;
  localparam int REP_PER = 3;

  logic ck  = 1'b0;
  logic rs  = 1'b0;
  logic btn = 1'b0;
  logic sw  = 1'b1;
  logic step;
  logic dir;
  logic busy;

  int n_cmp = 0;
  int n_err = 0;

  step_ctrl #(
    .DB_CYC (DB_CYC),
    .REP_DLY(REP_DLY),
    .REP_PER(REP_PER)
  ) dut (
    .ck  (ck),
    .rs  (rs),
    .btn (btn),
    .sw  (sw),
    .step(step),
    .dir (dir),
    .busy(busy)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic rs;
    logic btn;
    logic sw;
    logic step;
    logic dir;
    logic busy;
    int   tid;
    int   e;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic add(input int tid, input int e, input logic r, input logic b,
                     input logic s, input logic st, input logic d, input logic bz);
    vec_t v;
    v.rs = r; v.btn = b; v.sw = s; v.step = st; v.dir = d; v.busy = bz;
    v.tid = tid; v.e = e;
    vq.push_back(v);
  endtask

  // Clean press held 8 edges from edge k (e=0): step after k+6, busy k+2..k+13.
  task automatic add_press(input int tid);
    for (int e = 0; e < 18; e++)
      add(tid, e, 1'b1, (e < 8), 1'b1, (e == 6), 1'b1, (e >= 2 && e <= 13));
  endtask

  initial begin
    int   n_steps;
    logic exp_step;

    // Reset held with btn high and sw low: outputs stay at reset values.
    for (int e = 0; e < 20; e++) add(1, e, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Release with btn still held: full debounce before the only step.
    add_press(2);
    // Clean press from idle.
    add_press(3);
    // 3-cycle glitch: PRESS briefly, never a step.
    for (int e = 0; e < 8; e++)
      add(4, e, 1'b1, (e < 3), 1'b1, 1'b0, 1'b1, (e >= 2 && e <= 4));
    // Release bounce 0/1/0 after the press step.
    for (int e = 0; e < 18; e++)
      add(5, e, 1'b1, (e < 8 || e == 9), 1'b1, (e == 6), 1'b1, (e >= 2 && e <= 15));
    // sw low 6 edges together with a press: dir changes independently of the FSM.
    for (int e = 0; e < 18; e++)
      add(6, e, 1'b1, (e < 8), (e >= 6), (e == 6), !(e >= 5 && e <= 10),
          (e >= 2 && e <= 13));
    // 3-cycle sw pulse is one short of debounce; 4-cycle pulse is just enough.
    for (int e = 0; e < 12; e++) add(7, e, 1'b1, 1'b0, (e >= 3), 1'b0, 1'b1, 1'b0);
    for (int e = 0; e < 12; e++)
      add(8, e, 1'b1, 1'b0, (e >= 4), 1'b0, !(e >= 5 && e <= 8), 1'b0);

    foreach (vq[i]) begin
      rs  = vq[i].rs;
      btn = vq[i].btn;
      sw  = vq[i].sw;
      tick();
      check($sformatf("t%0d e%0d step", vq[i].tid, vq[i].e), step, vq[i].step);
      check($sformatf("t%0d e%0d dir",  vq[i].tid, vq[i].e), dir,  vq[i].dir);
      check($sformatf("t%0d e%0d busy", vq[i].tid, vq[i].e), busy, vq[i].busy);
    end

    // Auto-repeat: held 40 edges -> steps at 6, 16, 19, ..., 40.
    n_steps = 0;
    for (int e = 0; e < 50; e++) begin
      btn = (e < 40);
      tick();
      exp_step = (e == 6) || (e >= 16 && e <= 40 && ((e - 16) % 3) == 0);
      check($sformatf("rep e%0d step", e), step, exp_step);
      check($sformatf("rep e%0d busy", e), busy, (e >= 2 && e <= 45));
      if (step === 1'b1) n_steps++;
    end
    check_int("rep step count", n_steps, 10);

    // Async reset in REPEAT while a repeat step is high and dir is low.
    sw  = 1'b0;
    btn = 1'b1;
    for (int e = 0; e < 20; e++) tick();
    check("rst pre step", step, 1'b1);
    check("rst pre dir",  dir,  1'b0);
    check("rst pre busy", busy, 1'b1);
    #2;
    rs = 1'b0;
    #1;
    check("rst async step", step, 1'b0);
    check("rst async dir",  dir,  1'b1);
    check("rst async busy", busy, 1'b0);
    tick();
    tick();
    check("rst held busy", busy, 1'b0);
    rs  = 1'b1;
    btn = 1'b0;
    sw  = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      check($sformatf("post e%0d step", e), step, 1'b0);
      check($sformatf("post e%0d dir",  e), dir,  1'b1);
      check($sformatf("post e%0d busy", e), busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
